// File: rtl/rv32i_pkg.sv
// Shared constants for the multi-cycle RV32I core: opcodes, ALU op classes, mux selects, FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rv32i_pkg;

  // Opcodes (IR[6:0]) the controller dispatches on
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation class handed to the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Controller states; encodings 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_e;

endpackage

// File: rtl/rv32i_ctrl_outdec.sv
// Combinational decode of controller state (plus mem_ready/zero) into datapath controls.
// Latency: zero cycles, purely combinational.
// Backpressure: mem_ready qualifies ir_write, pc_write (in FETCH) and mem_write; illegal_op only with RV32I_CTRL_ILLEGAL_TRAP_EN.
module rv32i_ctrl_outdec
  import rv32i_pkg::*;
(
  input  state_e     state,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       imm_sel_j
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  logic pc_update;
  logic branch;

  // Moore decode: every control is 0 unless the current state names it
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALUOP_ADD;
    imm_sel_j  = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    illegal_op = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = mem_ready;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        imm_sel_j = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
        illegal_op = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // PC is written on unconditional update or a taken branch
  assign pc_write = pc_update | (branch & zero);

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core; optional trap-on-illegal via RV32I_CTRL_ILLEGAL_TRAP_EN.
// Latency: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles with mem_ready held high.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold with mem_req high until mem_ready; ready elsewhere is ignored.
module rv32i_multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       imm_sel_j,
  output logic [3:0] state_o
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

  // Reset into anything other than FETCH is not supported
  if (RESET_STATE_FETCH != 1) begin : g_reset_state_check
    $error("RESET_STATE_FETCH must be 1");
  end

  state_e state_q;
  state_e state_d;

  logic mem_write_raw;
  logic ir_write_raw;
  logic pc_write_raw;
  logic reg_write_raw;

  // Next-state: advance on mem_ready only in memory states, dispatch on opcode in DECODE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = S_ALUWB;
      S_EXEC_I:   state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL:  state_d = S_ILLEGAL;
`else
      S_ILLEGAL:  state_d = S_FETCH;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  rv32i_ctrl_outdec u_outdec (
    .state      (state_q),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .mem_req    (mem_req),
    .mem_write  (mem_write_raw),
    .adr_src    (adr_src),
    .ir_write   (ir_write_raw),
    .pc_write   (pc_write_raw),
    .reg_write  (reg_write_raw),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .imm_sel_j  (imm_sel_j)
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  // Write strobes are suppressed while reset is held, so FETCH cannot load IR/PC during reset
  assign mem_write = mem_write_raw & rst_n;
  assign ir_write  = ir_write_raw  & rst_n;
  assign pc_write  = pc_write_raw  & rst_n;
  assign reg_write = reg_write_raw & rst_n;

  assign state_o = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Directed self-checking bench for the multi-cycle RV32I control FSM.
// Latency: inputs change 1ns after the rising edge, outputs sampled 1ns later.
// Backpressure: mem_ready is driven low in memory states to exercise stalls.
module tb_rv32i_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, imm_sel_j;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0] state_o;
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rv32i_multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .imm_sel_j  (imm_sel_j),
    .state_o    (state_o)
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_op (illegal_op)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  // Check the state and the four write strobes in one go
  task automatic chk_cyc(input string tag, input int st, input logic irw, input logic pcw,
                         input logic rgw, input logic mw);
    chk({tag, ".state"},     32'(state_o),   32'(st));
    chk({tag, ".ir_write"},  32'(ir_write),  32'(irw));
    chk({tag, ".pc_write"},  32'(pc_write),  32'(pcw));
    chk({tag, ".reg_write"}, 32'(reg_write), 32'(rgw));
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(mw));
  endtask

  initial begin
    rst_n = 1'b0; op = 7'b0; zero = 1'b0; mem_ready = 1'b1;
    tick(); tick();

    // Reset values: FETCH, mem_req=1, src_b=10, result=10, strobes held low despite mem_ready
    chk_cyc("rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.mem_req",    32'(mem_req),    32'd1);
    chk("rst.alu_src_b",  32'(alu_src_b),  32'd2);
    chk("rst.result_src", 32'(result_src), 32'd2);
    chk("rst.alu_src_a",  32'(alu_src_a),  32'd0);
    chk("rst.alu_op",     32'(alu_op),     32'd0);
    chk("rst.adr_src",    32'(adr_src),    32'd0);
    chk("rst.imm_sel_j",  32'(imm_sel_j),  32'd0);
    rst_n = 1'b1;

    // R-type, mem_ready high: 0,1,6,8,0
    op = 7'b0110011; settle();
    chk_cyc("r.c0", 0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk_cyc("r.c1", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r.c1.src_a", 32'(alu_src_a), 32'd1);
    chk("r.c1.src_b", 32'(alu_src_b), 32'd1); tick();
    chk_cyc("r.c2", 6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("r.c2.alu_op", 32'(alu_op), 32'd2);
    chk("r.c2.src_a",  32'(alu_src_a), 32'd2);
    chk("r.c2.src_b",  32'(alu_src_b), 32'd0); tick();
    chk_cyc("r.c3", 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("r.c3.result", 32'(result_src), 32'd0); tick();

    // FETCH stall: no mem_ready keeps mem_req up and holds the state
    mem_ready = 1'b0; op = 7'b0010011; settle();
    chk_cyc("fstall.c0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fstall.mem_req", 32'(mem_req), 32'd1); tick();
    chk("fstall.c1.state", 32'(state_o), 32'd0);
    mem_ready = 1'b1; settle(); tick();
    chk("i.c1.state", 32'(state_o), 32'd1); tick();
    chk_cyc("i.c2", 7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("i.c2.src_b", 32'(alu_src_b), 32'd1);
    chk("i.c2.alu_op", 32'(alu_op), 32'd2); tick();
    chk_cyc("i.c3", 8, 1'b0, 1'b0, 1'b1, 1'b0); tick();

    // Load with 3-cycle stall in MEMREAD: 0,1,2,3,3,3,3,4,0
    op = 7'b0000011; settle();
    chk_cyc("lw.c0", 0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk_cyc("lw.c1", 1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk_cyc("lw.c2", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lw.c2.src_a", 32'(alu_src_a), 32'd2);
    chk("lw.c2.src_b", 32'(alu_src_b), 32'd1); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      settle();
      chk_cyc($sformatf("lw.rd%0d", i), 3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("lw.rd%0d.adr_src", i), 32'(adr_src), 32'd1);
      chk($sformatf("lw.rd%0d.mem_req", i), 32'(mem_req), 32'd1);
      chk($sformatf("lw.rd%0d.result", i), 32'(result_src), 32'd0);
      tick();
    end
    chk_cyc("lw.wb", 4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lw.wb.result", 32'(result_src), 32'd1); tick();
    chk("lw.end.state", 32'(state_o), 32'd0);

    // Store with one stall cycle: mem_write only when ready
    op = 7'b0100011; settle(); tick(); tick();
    chk("sw.c2.state", 32'(state_o), 32'd2); tick();
    mem_ready = 1'b0; settle();
    chk_cyc("sw.wait", 5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sw.wait.mem_req", 32'(mem_req), 32'd1);
    chk("sw.wait.adr_src", 32'(adr_src), 32'd1);
    mem_ready = 1'b1; settle();
    chk_cyc("sw.go", 5, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    chk("sw.end.state", 32'(state_o), 32'd0);

    // Branch taken then not taken; mem_ready low in DECODE is ignored
    op = 7'b1100011; zero = 1'b1; settle(); tick();
    mem_ready = 1'b0; settle();
    chk("beq1.c1.state", 32'(state_o), 32'd1); tick();
    chk_cyc("beq1.c2", 9, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("beq1.alu_op", 32'(alu_op), 32'd1);
    mem_ready = 1'b1; tick();
    zero = 1'b0; settle();
    chk("beq2.c0.state", 32'(state_o), 32'd0); tick(); tick();
    chk_cyc("beq2.c2", 9, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("beq2.alu_op", 32'(alu_op), 32'd1); tick();

    // JAL: 0,1,10,8
    op = 7'b1101111; settle();
    chk("jal.c0.state", 32'(state_o), 32'd0); tick(); tick();
    chk_cyc("jal.c2", 10, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jal.imm_sel_j", 32'(imm_sel_j), 32'd1);
    chk("jal.src_a", 32'(alu_src_a), 32'd1);
    chk("jal.src_b", 32'(alu_src_b), 32'd2); tick();
    chk_cyc("jal.c3", 8, 1'b0, 1'b0, 1'b1, 1'b0); tick();

    // Reset mid-MEMWRITE aborts the store
    op = 7'b0100011; settle(); tick(); tick(); tick();
    mem_ready = 1'b0; settle();
    chk("rmw.pre.state", 32'(state_o), 32'd5);
    rst_n = 1'b0; mem_ready = 1'b1; settle();
    chk_cyc("rmw.in", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1; mem_ready = 1'b0; settle();
    chk_cyc("rmw.out", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rmw.out.mem_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; settle();

    // Illegal opcode
    op = 7'b1111111; settle(); tick(); tick();
    chk_cyc("ill.c2", 11, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ill.c2.mem_req", 32'(mem_req), 32'd0);
`ifdef RV32I_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("ill.trap%0d.state", i), 32'(state_o), 32'd11);
      chk($sformatf("ill.trap%0d.flag", i), 32'(illegal_op), 32'd1);
      chk($sformatf("ill.trap%0d.pcw", i), 32'(pc_write), 32'd0);
      tick();
    end
    rst_n = 1'b0; settle();
    chk("ill.rst.state", 32'(state_o), 32'd0);
    chk("ill.rst.flag", 32'(illegal_op), 32'd0);
    rst_n = 1'b1;
`else
    tick();
    chk("ill.c3.state", 32'(state_o), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
